// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the UART instruction loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

   // Loader frame-parser states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN0 = 3'd1,
      LEN1 = 3'd2,
      DATA = 3'd3,
      CSUM = 3'd4,
      DONE = 3'd5,
      ERR  = 3'd6
   } loader_state_t;

   // First byte of every frame
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Clock cycles per UART bit, truncated
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_uart_loader_rx.sv
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART receiver with 2-flop synchronizer, false-start
//                rejection and stop-bit framing error report.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic          sync1_q, sync2_q, prev_q;
   logic [1:0]    st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   // Next-state logic: all sampling is timed from the middle of the start bit
   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (st_q)
         RX_IDLE: begin
            // Falling edge on the synchronized line begins a start bit
            if (prev_q && !sync2_q) begin
               cnt_d = '0;
               st_d  = RX_START;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               bit_d = '0;
               // Line back high at mid-start means it was only a glitch
               st_d  = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) st_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               valid_d = sync2_q;
               ferr_d  = !sync2_q;
               st_d    = RX_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Synchronizer and receiver state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         st_q    <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_byte  = shift_q;
   assign rx_valid = valid_q;
   assign rx_ferr  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/imem_uart_loader.sv
// ============================================================================
//  Module      : imem_uart_loader
//  Description : Parses framed program images from a UART and writes 32-bit
//                words into instruction memory, holding the core meanwhile.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_uart_loader
   import imem_loader_pkg::*;
#(
   parameter int          CLK_FREQ       = 50_000_000,
   parameter int          BAUD           = 115200,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          MAX_WORDS      = 256,
   parameter int          TIMEOUT_CYCLES = 5_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_rx,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_ferr;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (clk),
      .reset    (reset),
      .rx       (uart_rx),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   loader_state_t state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   words_q, words_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic [31:0]   word_q, word_d;
   logic [7:0]    csum_q, csum_d;
   logic [31:0]   tmo_q, tmo_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          in_frame;
   logic [15:0]   len_full;
   logic [31:0]   word_next;

   assign in_frame  = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CSUM);
   assign len_full  = {rx_byte, len_q[7:0]};
   assign word_next = {rx_byte, word_q[31:8]};

   // Frame parser: sync detect, length check, word assembly, checksum, timeout
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      words_d = words_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      csum_d  = csum_q;
      tmo_d   = '0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_d  = done_q;
      error_d = error_q;

      if (in_frame) begin
         tmo_d = rx_valid ? 32'd0 : tmo_q + 32'd1;
         if (rx_ferr || (!rx_valid && tmo_d == 32'(TIMEOUT_CYCLES))) begin
            state_d = ERR;
            error_d = 1'b1;
         end else if (rx_valid) begin
            csum_d = csum_q ^ rx_byte;
            case (state_q)
               LEN0: begin
                  len_d   = {8'h00, rx_byte};
                  state_d = LEN1;
               end
               LEN1: begin
                  len_d = len_full;
                  if (len_full > 16'(MAX_WORDS)) begin
                     state_d = ERR;
                     error_d = 1'b1;
                  end else if (len_full == 16'd0) begin
                     state_d = CSUM;
                  end else begin
                     state_d = DATA;
                  end
               end
               DATA: begin
                  word_d = word_next;
                  bcnt_d = bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     we_d    = 1'b1;
                     wdata_d = word_next;
                     addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
                     words_d = words_q + 16'd1;
                     if (words_q + 16'd1 == len_q) state_d = CSUM;
                  end
               end
               default: begin
                  // Checksum byte itself is not folded into the running XOR
                  csum_d = csum_q;
                  if (rx_byte == csum_q) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ERR;
                     error_d = 1'b1;
                  end
               end
            endcase
         end
      end else if (rx_valid && rx_byte == SYNC_BYTE) begin
         state_d = LEN0;
         done_d  = 1'b0;
         error_d = 1'b0;
         words_d = '0;
         bcnt_d  = '0;
         csum_d  = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         words_q <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         csum_q  <= '0;
         tmo_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         words_q <= words_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         csum_q  <= csum_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign cpu_hold     = in_frame;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

`default_nettype wire
